// File: rtl/regfile_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_fifo_ctrl
// Brief    : FIFO controller over an external register file with a 3-state
//            (IDLE/READ/CAPTURE) registered read path.
// Revision : 1.0
// ============================================================================
module regfile_fifo_ctrl #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Push,
    input  logic [D_WIDTH-1:0] Push_Data,
    output logic               Full,
    input  logic               Pop,
    output logic               Pop_Ready,
    output logic [D_WIDTH-1:0] Pop_Data,
    output logic               Pop_Valid,
    output logic               Empty,
    output logic [A_WIDTH:0]   Count,
    output logic               Overflow,
    output logic               Underflow,
    output logic [A_WIDTH-1:0] RF_W_Addr,
    output logic               RF_W_en,
    output logic [D_WIDTH-1:0] RF_W_Data,
    output logic [A_WIDTH-1:0] RF_R_Addr,
    output logic               RF_R_en,
    input  logic [D_WIDTH-1:0] RF_R_Data
);

    localparam logic [A_WIDTH:0]   c_DEPTH   = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH:0]   c_CNT_ONE = (A_WIDTH+1)'(1);
    localparam logic [A_WIDTH-1:0] c_PTR_ONE = A_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [A_WIDTH-1:0]   r_wr_ptr;
    logic [A_WIDTH-1:0]   r_rd_ptr;
    logic [A_WIDTH:0]     r_count;
    logic [D_WIDTH-1:0]   r_pop_data;
    logic                 r_pop_valid;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_idle;
    logic                 w_pop_ready;
    logic                 w_wr_en;
    logic                 w_capture;

    // Status flags derive only from registered count/state.
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_idle      = (r_state == S_IDLE);
    assign w_pop_ready = w_idle & ~w_empty;
    assign w_capture   = (r_state == S_CAPTURE);
    // Rst gates the write strobe so nothing reaches the register file in reset.
    assign w_wr_en     = Push & ~w_full & ~Rst;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (Pop && w_pop_ready) w_state_nxt = S_READ;
            S_READ:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            // The entry being read stays counted until captured, so the
            // write pointer can never land on rd_ptr mid-read.
            if (w_capture) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_pop_data <= RF_R_Data;
            end
            case ({w_wr_en, w_capture})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_pop_valid <= w_capture;
            r_overflow  <= Push & w_full;
            r_underflow <= Pop & w_empty & w_idle;
        end
    end

    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Pop_Ready = w_pop_ready;
    assign Count     = r_count;
    assign Pop_Data  = r_pop_data;
    assign Pop_Valid = r_pop_valid;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;
    assign RF_W_en   = w_wr_en;
    assign RF_W_Addr = r_wr_ptr;
    assign RF_W_Data = Push_Data;
    assign RF_R_en   = ~w_idle;
    assign RF_R_Addr = r_rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_fifo_ctrl
// Brief    : Self-checking bench for regfile_fifo_ctrl with a register file model.
// Revision : 1.0
// ============================================================================
module tb_regfile_fifo_ctrl;

    logic        Clk;
    logic        Rst;
    logic        Push;
    logic [31:0] Push_Data;
    logic        Full;
    logic        Pop;
    logic        Pop_Ready;
    logic [31:0] Pop_Data;
    logic        Pop_Valid;
    logic        Empty;
    logic [2:0]  Count;
    logic        Overflow;
    logic        Underflow;
    logic [1:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [31:0] RF_W_Data;
    logic [1:0]  RF_R_Addr;
    logic        RF_R_en;
    logic [31:0] RF_R_Data;

    regfile_fifo_ctrl #(.D_WIDTH(32), .A_WIDTH(2)) dut (
        .Clk(Clk), .Rst(Rst), .Push(Push), .Push_Data(Push_Data), .Full(Full),
        .Pop(Pop), .Pop_Ready(Pop_Ready), .Pop_Data(Pop_Data), .Pop_Valid(Pop_Valid),
        .Empty(Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow),
        .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_W_Data(RF_W_Data),
        .RF_R_Addr(RF_R_Addr), .RF_R_en(RF_R_en), .RF_R_Data(RF_R_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file: synchronous write, combinational read.
    logic [31:0] mem [4];
    always @(posedge Clk) begin
        if (RF_W_en) mem[RF_W_Addr] <= RF_W_Data;
    end
    assign RF_R_Data = RF_R_en ? mem[RF_R_Addr] : 32'd0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (!Rst && Pop_Valid) begin
            if (sb_q.size() == 0) check("sb_unexpected_valid", 32'd1, 32'd0);
            else                  check("sb_pop_data", Pop_Data, sb_q.pop_front());
        end
    end

    typedef struct {
        logic        push;
        logic [31:0] data;
        logic        pop;
        logic        wen;
        logic [1:0]  waddr;
        logic [2:0]  count;
        logic        full;
        logic        empty;
        logic        rdy;
        logic        ovf;
        logic        unf;
        logic        valid;
    } vec_t;

    function automatic vec_t mk(input logic pu, input logic [31:0] d, input logic po,
                                input logic we, input logic [1:0] wa, input logic [2:0] c,
                                input logic f, input logic e, input logic r,
                                input logic o, input logic u, input logic v);
        vec_t t;
        t.push = pu; t.data = d; t.pop = po; t.wen = we; t.waddr = wa; t.count = c;
        t.full = f; t.empty = e; t.rdy = r; t.ovf = o; t.unf = u; t.valid = v;
        return t;
    endfunction

    task automatic do_push(input logic [31:0] d, input logic [1:0] exp_addr,
                           input logic exp_acc, input logic [2:0] exp_cnt);
        Push = 1'b1;
        Push_Data = d;
        #1;
        check("push_wen", RF_W_en, exp_acc);
        if (exp_acc) begin
            check("push_waddr", RF_W_Addr, exp_addr);
            sb_q.push_back(d);
        end
        @(posedge Clk); #1;
        Push = 1'b0;
        check("push_count", Count, exp_cnt);
    endtask

    task automatic do_pop(input logic [1:0] exp_raddr, input logic [2:0] exp_cnt);
        int lat;
        Pop = 1'b1;
        #1;
        check("pop_ready", Pop_Ready, 1'b1);
        @(posedge Clk); #1;
        Pop = 1'b0;
        check("pop_rd_en", RF_R_en, 1'b1);
        check("pop_raddr", RF_R_Addr, exp_raddr);
        lat = 1;
        while (!Pop_Valid && lat < 8) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("pop_latency", lat, 3);
        check("pop_count", Count, exp_cnt);
    endtask

    vec_t vecs [20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(1, 32'd0, 0, 1, 2'd0, 3'd1, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 32'd1, 0, 1, 2'd1, 3'd2, 0, 0, 1, 0, 0, 0);
        vecs[2]  = mk(1, 32'd2, 0, 1, 2'd2, 3'd3, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mk(1, 32'd3, 0, 1, 2'd3, 3'd4, 1, 0, 1, 0, 0, 0);
        vecs[4]  = mk(1, 32'd4, 0, 0, 2'd0, 3'd4, 1, 0, 1, 1, 0, 0);
        vecs[5]  = mk(0, 32'd0, 0, 0, 2'd0, 3'd4, 1, 0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 32'd0, 1, 0, 2'd0, 3'd4, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 32'd0, 0, 0, 2'd0, 3'd4, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 32'd0, 0, 0, 2'd0, 3'd3, 0, 0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 32'd0, 1, 0, 2'd0, 3'd3, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 32'd0, 0, 0, 2'd0, 3'd3, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 32'd0, 0, 0, 2'd0, 3'd2, 0, 0, 1, 0, 0, 1);
        vecs[12] = mk(0, 32'd0, 1, 0, 2'd0, 3'd2, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 32'd0, 1, 0, 2'd0, 3'd2, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 32'd0, 1, 0, 2'd0, 3'd1, 0, 0, 1, 0, 0, 1);
        vecs[15] = mk(0, 32'd0, 1, 0, 2'd0, 3'd1, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 32'd0, 0, 0, 2'd0, 3'd1, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(0, 32'd0, 0, 0, 2'd0, 3'd0, 0, 1, 0, 0, 0, 1);
        vecs[18] = mk(0, 32'd0, 1, 0, 2'd0, 3'd0, 0, 1, 0, 0, 1, 0);
        vecs[19] = mk(0, 32'd0, 0, 0, 2'd0, 3'd0, 0, 1, 0, 0, 0, 0);

        Rst = 1'b1; Push = 1'b0; Pop = 1'b0; Push_Data = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_count", Count, 3'd0);
        check("rst_empty", Empty, 1'b1);
        check("rst_full", Full, 1'b0);
        check("rst_ready", Pop_Ready, 1'b0);
        check("rst_valid", Pop_Valid, 1'b0);
        Rst = 1'b0;

        // Fill, overflow, drain with ignored pops, underflow.
        for (int i = 0; i < 20; i++) begin
            Push = vecs[i].push; Push_Data = vecs[i].data; Pop = vecs[i].pop;
            #1;
            check($sformatf("v%0d_wen", i), RF_W_en, vecs[i].wen);
            if (vecs[i].wen) begin
                check($sformatf("v%0d_waddr", i), RF_W_Addr, vecs[i].waddr);
                sb_q.push_back(vecs[i].data);
            end
            @(posedge Clk); #1;
            check($sformatf("v%0d_count", i), Count, vecs[i].count);
            check($sformatf("v%0d_full", i), Full, vecs[i].full);
            check($sformatf("v%0d_empty", i), Empty, vecs[i].empty);
            check($sformatf("v%0d_ready", i), Pop_Ready, vecs[i].rdy);
            check($sformatf("v%0d_ovf", i), Overflow, vecs[i].ovf);
            check($sformatf("v%0d_unf", i), Underflow, vecs[i].unf);
            check($sformatf("v%0d_valid", i), Pop_Valid, vecs[i].valid);
        end
        Push = 1'b0; Pop = 1'b0;

        // Interleaved wrap: both pointers cross 3 -> 0.
        do_push(32'hA000_0000, 2'd0, 1, 3'd1);
        do_push(32'hA000_0001, 2'd1, 1, 3'd2);
        do_pop(2'd0, 3'd1);
        do_push(32'hA000_0002, 2'd2, 1, 3'd2);
        do_pop(2'd1, 3'd1);
        do_push(32'hA000_0003, 2'd3, 1, 3'd2);
        do_push(32'hA000_0004, 2'd0, 1, 3'd3);
        do_pop(2'd2, 3'd2);
        do_push(32'hA000_0005, 2'd1, 1, 3'd3);
        do_pop(2'd3, 3'd2);
        do_pop(2'd0, 3'd1);
        do_pop(2'd1, 3'd0);
        check("wrap_empty", Empty, 1'b1);

        // Full plus push on the capture edge: blocked, then lands at freed slot.
        do_push(32'hB000_0000, 2'd2, 1, 3'd1);
        do_push(32'hB000_0001, 2'd3, 1, 3'd2);
        do_push(32'hB000_0002, 2'd0, 1, 3'd3);
        do_push(32'hB000_0003, 2'd1, 1, 3'd4);
        check("sim_full", Full, 1'b1);
        Pop = 1'b1;
        @(posedge Clk); #1;
        Pop = 1'b0;
        @(posedge Clk); #1;
        check("sim_capture_count", Count, 3'd4);
        Push = 1'b1; Push_Data = 32'hC000_0000;
        #1;
        check("sim_capture_wen", RF_W_en, 1'b0);
        @(posedge Clk); #1;
        Push = 1'b0;
        check("sim_valid", Pop_Valid, 1'b1);
        check("sim_count", Count, 3'd3);
        check("sim_full_after", Full, 1'b0);
        check("sim_ovf", Overflow, 1'b1);
        do_push(32'hC000_0001, 2'd2, 1, 3'd4);
        check("sim_refull", Full, 1'b1);
        do_pop(2'd3, 3'd3);
        do_pop(2'd0, 3'd2);
        do_pop(2'd1, 3'd1);
        do_pop(2'd2, 3'd0);

        // Asynchronous reset during CAPTURE.
        do_push(32'hD000_0000, 2'd3, 1, 3'd1);
        do_push(32'hD000_0001, 2'd0, 1, 3'd2);
        Pop = 1'b1;
        @(posedge Clk); #1;
        Pop = 1'b0;
        @(posedge Clk); #1;
        Push = 1'b1; Push_Data = 32'hEEEE_EEEE; Pop = 1'b1;
        #2;
        Rst = 1'b1;
        #1;
        check("mid_rst_count", Count, 3'd0);
        check("mid_rst_empty", Empty, 1'b1);
        check("mid_rst_full", Full, 1'b0);
        check("mid_rst_ready", Pop_Ready, 1'b0);
        check("mid_rst_valid", Pop_Valid, 1'b0);
        check("mid_rst_pdata", Pop_Data, 32'd0);
        check("mid_rst_wen", RF_W_en, 1'b0);
        check("mid_rst_ren", RF_R_en, 1'b0);
        check("mid_rst_waddr", RF_W_Addr, 2'd0);
        check("mid_rst_raddr", RF_R_Addr, 2'd0);
        check("mid_rst_ovf", Overflow, 1'b0);
        check("mid_rst_unf", Underflow, 1'b0);
        Push = 1'b0; Pop = 1'b0;
        sb_q.delete();
        @(posedge Clk); #1;
        check("rst_hold_valid", Pop_Valid, 1'b0);
        Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            check($sformatf("post_rst_valid%0d", k), Pop_Valid, 1'b0);
            check($sformatf("post_rst_count%0d", k), Count, 3'd0);
        end
        do_push(32'hF000_0000, 2'd0, 1, 3'd1);
        do_pop(2'd0, 3'd0);

        @(posedge Clk); #1;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
